// File: rtl/switch_alloc7.sv
// ---------------------------------------------------------------------------
// switch_alloc7 -- separable 7-input x 7-output switch allocator.
//
// Each output j runs its own small allocator. It combines:
//   * round-robin arbitration over the inputs whose head flit requests j;
//   * wormhole locking, so a multi-flit packet keeps the output until its tail;
//   * credit-based flow control against the downstream buffer (cnt_j).
// An input that owns a locked output is hidden from every other output. As a
// result, one input never receives two grants in the same cycle.
//
// Parameters:
//   CREDITS  downstream buffer depth per output; reset and maximum credit count
//   CW       credit counter width (must hold CREDITS)
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   vc_valid   [6:0]  bit i-1: input i has a flit at its buffer head
//   dest       [20:0] {d7..d1}, 3 bits each; requested output (0 = none)
//   tail       [6:0]  bit i-1: input i's head flit is a tail
//   credit_in  [6:0]  bit j-1: one credit returned for output j
//   sa1..sa7   [2:0]  combinational grant select per output (0 = none, k = input k)
//   err               sticky protocol-error flag
//
// Optional feature: define SWITCH_ALLOC7_ERR_EN to enable the err detector.
// The detector flags two conditions:
//   * a credit returned to an output that already holds full credit;
//   * a valid head flit with dest 0 from an input that is not an owner.
// If the macro is not defined, err is tied to 0.
// ---------------------------------------------------------------------------
module switch_alloc7 #(
    parameter int CREDITS = 4,
    parameter int CW      = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  vc_valid,
    input  logic [20:0] dest,
    input  logic [6:0]  tail,
    input  logic [6:0]  credit_in,
    output logic [2:0]  sa1,
    output logic [2:0]  sa2,
    output logic [2:0]  sa3,
    output logic [2:0]  sa4,
    output logic [2:0]  sa5,
    output logic [2:0]  sa6,
    output logic [2:0]  sa7,
    output logic        err
);

    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Per-output state, flattened into packed buses so that other outputs
    // can see it.
    logic [6:0]  locked_bus;   // bit j: output j+1 is LOCKED
    logic [20:0] owner_bus;    // 3 bits per output: owning input (1..7)
    logic [20:0] sa_bus;       // 3 bits per output: grant select
    logic [6:0]  send_bus;     // bit j: a flit leaves through output j+1
    logic [6:0]  owner_busy;   // bit i: input i+1 owns some LOCKED output

    // An input that owns any locked output may not compete elsewhere.
    always_comb begin
        owner_busy = '0;
        for (int j = 0; j < 7; j++) begin
            for (int i = 0; i < 7; i++) begin
                if (locked_bus[j] && (owner_bus[3*j +: 3] == 3'(i + 1))) begin
                    owner_busy[i] = 1'b1;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_out
            state_t          state_reg;
            logic [2:0]      owner_reg;
            logic [2:0]      rr_ptr_reg;  // last granted input, 1..7
            logic [CW-1:0]   cnt_reg;

            logic [6:0]      cand;
            logic            found;
            logic [2:0]      winner;
            logic [2:0]      sel;
            logic            send;

            // Candidate inputs: valid head flit that names this output and
            // whose input is not tied up by a lock on another output.
            always_comb begin
                cand = '0;
                for (int i = 0; i < 7; i++) begin
                    cand[i] = vc_valid[i]
                              && (dest[3*i +: 3] == 3'(gi + 1))
                              && !owner_busy[i];
                end
            end

            // Round-robin scan that starts just after the last winner.
            // rr_ptr_reg is 1-based. (rr_ptr-1+k) mod 7 is therefore the
            // 0-based index of input rr_ptr+k, with wrap-around from 7 to 1.
            always_comb begin
                int idx;
                found  = 1'b0;
                winner = 3'd0;
                idx    = 0;
                for (int k = 1; k <= 7; k++) begin
                    idx = (int'(rr_ptr_reg) - 1 + k) % 7;
                    if (!found && cand[idx]) begin
                        found  = 1'b1;
                        winner = 3'(idx + 1);
                    end
                end
            end

            // Grant select. A locked output always serves its owner, even
            // during bubbles. Without credit, the select stays at 0.
            always_comb begin
                sel = 3'd0;
                if (!rst_n) begin
                    sel = 3'd0;
                end else if (state_reg == LOCKED) begin
                    if (cnt_reg != '0) begin
                        sel = owner_reg;
                    end
                end else if ((cnt_reg != '0) && found) begin
                    sel = winner;
                end
            end

            // A flit actually leaves only when the granted input has one. This
            // matches the pop that the pop-control logic generates.
            assign send = (sel != 3'd0) && vc_valid[3'(sel - 3'd1)];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg  <= IDLE;
                    owner_reg  <= 3'd0;
                    rr_ptr_reg <= 3'd7;
                    cnt_reg    <= CRED_MAX;
                end else begin
                    case (state_reg)
                        IDLE: begin
                            // In IDLE, a nonzero select always comes from a
                            // valid candidate, so it always implies a send.
                            if (sel != 3'd0) begin
                                rr_ptr_reg <= winner;
                                if (!tail[3'(winner - 3'd1)]) begin
                                    state_reg <= LOCKED;
                                    owner_reg <= winner;
                                end
                            end
                        end
                        LOCKED: begin
                            if (send && tail[3'(owner_reg - 3'd1)]) begin
                                state_reg <= IDLE;
                            end
                        end
                        default: state_reg <= IDLE;
                    endcase

                    // Credit accounting. A send and a credit in the same
                    // cycle cancel out. A surplus credit saturates at
                    // CREDITS.
                    case ({send, credit_in[gi]})
                        2'b10:   cnt_reg <= cnt_reg - CW'(1);
                        2'b01:   if (cnt_reg != CRED_MAX) cnt_reg <= cnt_reg + CW'(1);
                        default: cnt_reg <= cnt_reg;
                    endcase
                end
            end

            assign locked_bus[gi]       = (state_reg == LOCKED);
            assign owner_bus[3*gi +: 3] = owner_reg;
            assign sa_bus[3*gi +: 3]    = sel;
            assign send_bus[gi]         = send;
        end
    endgenerate

    assign sa1 = sa_bus[2:0];
    assign sa2 = sa_bus[5:3];
    assign sa3 = sa_bus[8:6];
    assign sa4 = sa_bus[11:9];
    assign sa5 = sa_bus[14:12];
    assign sa6 = sa_bus[17:15];
    assign sa7 = sa_bus[20:18];

`ifdef SWITCH_ALLOC7_ERR_EN
    logic [6:0] full_bus;     // bit j: output j+1 holds full credit
    logic [6:0] surplus_err;  // credit returned to a full output
    logic [6:0] nodest_err;   // valid head with no destination
    logic       err_reg;

    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_err
            assign full_bus[gi]    = (g_out[gi].cnt_reg == CRED_MAX);
            assign surplus_err[gi] = credit_in[gi] && full_bus[gi] && !send_bus[gi];
            assign nodest_err[gi]  = vc_valid[gi] && (dest[3*gi +: 3] == 3'd0)
                                     && !owner_busy[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if ((|surplus_err) || (|nodest_err)) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_switch_alloc7.sv
// ---------------------------------------------------------------------------
// Testbench for switch_alloc7 (default CREDITS=4).
// Every scenario is a table of per-cycle rows. A row holds the inputs to drive
// and the hand-derived grant/err values expected during that cycle. For each
// row, the expectation is pushed to the scoreboard queue, the stimulus is
// applied at the falling edge, and the DUT outputs are sampled 2 ns later and
// compared against the popped entry.
// ---------------------------------------------------------------------------
module tb_switch_alloc7;

    logic        clk;
    logic        rst_n;
    logic [6:0]  vc_valid;
    logic [20:0] dest;
    logic [6:0]  tail;
    logic [6:0]  credit_in;
    logic [2:0]  sa1, sa2, sa3, sa4, sa5, sa6, sa7;
    logic        err;

`ifdef SWITCH_ALLOC7_ERR_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    typedef struct {
        logic [6:0]  vv;
        logic [20:0] dst;
        logic [6:0]  tl;
        logic [6:0]  cr;
        logic        rs;
        logic [20:0] sa;
        logic        er;
    } row_t;

    typedef struct {
        logic [20:0] sa;
        logic        er;
    } exp_t;

    exp_t exp_q[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;

    switch_alloc7 #(.CREDITS(4), .CW(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vc_valid  (vc_valid),
        .dest      (dest),
        .tail      (tail),
        .credit_in (credit_in),
        .sa1       (sa1),
        .sa2       (sa2),
        .sa3       (sa3),
        .sa4       (sa4),
        .sa5       (sa5),
        .sa6       (sa6),
        .sa7       (sa7),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Places a 3-bit value v in field k (1..7) of a 21-bit {x7..x1} vector.
    function automatic logic [20:0] f3(input int k, input int v);
        logic [20:0] x;
        x = '0;
        x[3*(k-1) +: 3] = 3'(v);
        return x;
    endfunction

    function automatic row_t r(input logic [6:0] vv, input logic [20:0] dst,
                               input logic [6:0] tl, input logic [6:0] cr,
                               input logic rs, input logic [20:0] sa,
                               input logic er);
        row_t x;
        x.vv = vv; x.dst = dst; x.tl = tl; x.cr = cr;
        x.rs = rs; x.sa = sa; x.er = er;
        return x;
    endfunction

    task automatic drive(input row_t x);
        @(negedge clk);
        rst_n     = x.rs;
        vc_valid  = x.vv;
        dest      = x.dst;
        tail      = x.tl;
        credit_in = x.cr;
        #2;
    endtask

    task automatic test_reset();
        row_t rows[$];
        exp_t e;
        logic [20:0] obs;
        rows.push_back(r(7'b0000001, f3(1,1), 7'b0000001, 7'b0, 1'b0, 21'h0, 1'b0));
        rows.push_back(r(7'b0000100, f3(3,5), 7'b0000100, 7'b0010000, 1'b0, 21'h0, 1'b0));
        rows.push_back(r(7'b0, 21'h0, 7'b0, 7'b0, 1'b1, 21'h0, 1'b0));
        foreach (rows[k]) begin
            exp_q.push_back('{sa: rows[k].sa, er: rows[k].er});
            drive(rows[k]);
            e   = exp_q.pop_front();
            obs = {sa7, sa6, sa5, sa4, sa3, sa2, sa1};
            $display("test_reset row %0d: sa=%h err=%b", k, obs, err);
            n_compared++;
            if (obs !== e.sa) begin
                n_mismatched++;
                $display("FAIL test_reset row %0d sa: got %h required %h", k, obs, e.sa);
            end
            n_compared++;
            if (err !== e.er) begin
                n_mismatched++;
                $display("FAIL test_reset row %0d err: got %b required %b", k, err, e.er);
            end
        end
    endtask

    task automatic test_single_flit();
        row_t rows[$];
        exp_t e;
        logic [20:0] obs;
        logic [20:0] all_d;
        logic [20:0] all_sa;
        all_d  = '0;
        all_sa = '0;
        // Input i -> output 8-i, so every output has exactly one requester.
        for (int i = 1; i <= 7; i++) begin
            all_d  = all_d | f3(i, 8 - i);
            all_sa = all_sa | f3(8 - i, i);
        end
        rows.push_back(r(7'b0, 21'h0, 7'b0, 7'b0, 1'b0, 21'h0, 1'b0));
        rows.push_back(r(7'b0000100, f3(3,5), 7'b0000100, 7'b0, 1'b1, f3(5,3), 1'b0));
        // rr_ptr5 is now 3, so input 4 beats input 3.
        rows.push_back(r(7'b0001100, f3(3,5) | f3(4,5), 7'b0001100, 7'b0, 1'b1, f3(5,4), 1'b0));
        rows.push_back(r(7'b0, 21'h0, 7'b0, 7'b0, 1'b1, 21'h0, 1'b0));
        rows.push_back(r(7'b1111111, all_d, 7'b1111111, 7'b0, 1'b1, all_sa, 1'b0));
        foreach (rows[k]) begin
            exp_q.push_back('{sa: rows[k].sa, er: rows[k].er});
            drive(rows[k]);
            e   = exp_q.pop_front();
            obs = {sa7, sa6, sa5, sa4, sa3, sa2, sa1};
            $display("test_single_flit row %0d: sa=%h err=%b", k, obs, err);
            n_compared++;
            if (obs !== e.sa) begin
                n_mismatched++;
                $display("FAIL test_single_flit row %0d sa: got %h required %h", k, obs, e.sa);
            end
        end
    endtask

    task automatic test_round_robin();
        row_t rows[$];
        exp_t e;
        logic [20:0] obs;
        int seq [6];
        seq = '{1, 2, 4, 1, 2, 4};
        rows.push_back(r(7'b0, 21'h0, 7'b0, 7'b0, 1'b0, 21'h0, 1'b0));
        for (int c = 0; c < 6; c++) begin
            rows.push_back(r(7'b0001011, f3(1,2) | f3(2,2) | f3(4,2), 7'b0001011,
                             7'b0000010, 1'b1, f3(2, seq[c]), 1'b0));
        end
        foreach (rows[k]) begin
            exp_q.push_back('{sa: rows[k].sa, er: rows[k].er});
            drive(rows[k]);
            e   = exp_q.pop_front();
            obs = {sa7, sa6, sa5, sa4, sa3, sa2, sa1};
            $display("test_round_robin row %0d: sa=%h err=%b", k, obs, err);
            n_compared++;
            if (obs !== e.sa) begin
                n_mismatched++;
                $display("FAIL test_round_robin row %0d sa: got %h required %h", k, obs, e.sa);
            end
            n_compared++;
            if (err !== e.er) begin
                n_mismatched++;
                $display("FAIL test_round_robin row %0d err: got %b required %b", k, err, e.er);
            end
        end
    endtask

    task automatic test_wormhole();
        row_t rows[$];
        exp_t e;
        logic [20:0] obs;
        rows.push_back(r(7'b0, 21'h0, 7'b0, 7'b0, 1'b0, 21'h0, 1'b0));
        // Input 5 sends first so that rr_ptr1 = 5 and input 6 is next in line.
        rows.push_back(r(7'b0010000, f3(5,1), 7'b0010000, 7'b0, 1'b1, f3(1,5), 1'b0));
        // Head from input 6; input 2 also wants output 1.
        rows.push_back(r(7'b0100010, f3(6,1) | f3(2,1), 7'b0000010, 7'b0000001, 1'b1, f3(1,6), 1'b0));
        // Body, bubble and body, all with garbage d6 = 3.
        rows.push_back(r(7'b0100010, f3(6,3) | f3(2,1), 7'b0000010, 7'b0000001, 1'b1, f3(1,6), 1'b0));
        rows.push_back(r(7'b0000010, f3(6,3) | f3(2,1), 7'b0000010, 7'b0000001, 1'b1, f3(1,6), 1'b0));
        rows.push_back(r(7'b0100010, f3(6,3) | f3(2,1), 7'b0000010, 7'b0000001, 1'b1, f3(1,6), 1'b0));
        // Tail.
        rows.push_back(r(7'b0100010, f3(6,3) | f3(2,1), 7'b0100010, 7'b0000001, 1'b1, f3(1,6), 1'b0));
        // The lock is released, so input 2 wins.
        rows.push_back(r(7'b0000010, f3(2,1), 7'b0000010, 7'b0, 1'b1, f3(1,2), 1'b0));
        foreach (rows[k]) begin
            exp_q.push_back('{sa: rows[k].sa, er: rows[k].er});
            drive(rows[k]);
            e   = exp_q.pop_front();
            obs = {sa7, sa6, sa5, sa4, sa3, sa2, sa1};
            $display("test_wormhole row %0d: sa=%h err=%b", k, obs, err);
            n_compared++;
            if (obs !== e.sa) begin
                n_mismatched++;
                $display("FAIL test_wormhole row %0d sa: got %h required %h", k, obs, e.sa);
            end
            n_compared++;
            if (err !== e.er) begin
                n_mismatched++;
                $display("FAIL test_wormhole row %0d err: got %b required %b", k, err, e.er);
            end
        end
    endtask

    task automatic test_credit_exhaust();
        row_t rows[$];
        exp_t e;
        logic [20:0] obs;
        rows.push_back(r(7'b0, 21'h0, 7'b0, 7'b0, 1'b0, 21'h0, 1'b0));
        for (int c = 0; c < 4; c++) begin
            rows.push_back(r(7'b0000001, f3(1,7), 7'b0000001, 7'b0, 1'b1, f3(7,1), 1'b0));
        end
        rows.push_back(r(7'b0000001, f3(1,7), 7'b0000001, 7'b0, 1'b1, 21'h0, 1'b0));
        rows.push_back(r(7'b0000001, f3(1,7), 7'b0000001, 7'b1000000, 1'b1, 21'h0, 1'b0));
        rows.push_back(r(7'b0000001, f3(1,7), 7'b0000001, 7'b0, 1'b1, f3(7,1), 1'b0));
        rows.push_back(r(7'b0000001, f3(1,7), 7'b0000001, 7'b0, 1'b1, 21'h0, 1'b0));
        foreach (rows[k]) begin
            exp_q.push_back('{sa: rows[k].sa, er: rows[k].er});
            drive(rows[k]);
            e   = exp_q.pop_front();
            obs = {sa7, sa6, sa5, sa4, sa3, sa2, sa1};
            $display("test_credit_exhaust row %0d: sa=%h err=%b", k, obs, err);
            n_compared++;
            if (obs !== e.sa) begin
                n_mismatched++;
                $display("FAIL test_credit_exhaust row %0d sa: got %h required %h", k, obs, e.sa);
            end
        end
    endtask

    task automatic test_credit_and_reset();
        row_t rows[$];
        exp_t e;
        logic [20:0] obs;
        rows.push_back(r(7'b0, 21'h0, 7'b0, 7'b0, 1'b0, 21'h0, 1'b0));
        // Two sends bring cnt4 to 2. Then a send and a credit arrive together.
        rows.push_back(r(7'b0000001, f3(1,4), 7'b0000001, 7'b0, 1'b1, f3(4,1), 1'b0));
        rows.push_back(r(7'b0000001, f3(1,4), 7'b0000001, 7'b0, 1'b1, f3(4,1), 1'b0));
        rows.push_back(r(7'b0000001, f3(1,4), 7'b0000001, 7'b0001000, 1'b1, f3(4,1), 1'b0));
        // Exactly two more grants prove that cnt4 stayed at 2.
        rows.push_back(r(7'b0000001, f3(1,4), 7'b0000001, 7'b0, 1'b1, f3(4,1), 1'b0));
        rows.push_back(r(7'b0000001, f3(1,4), 7'b0000001, 7'b0, 1'b1, f3(4,1), 1'b0));
        rows.push_back(r(7'b0000001, f3(1,4), 7'b0000001, 7'b0, 1'b1, 21'h0, 1'b0));
        // Input 3 starts a packet on output 1; reset hits mid-packet.
        rows.push_back(r(7'b0000100, f3(3,1), 7'b0, 7'b0, 1'b1, f3(1,3), 1'b0));
        rows.push_back(r(7'b0000100, f3(3,1), 7'b0, 7'b0, 1'b1, f3(1,3), 1'b0));
        rows.push_back(r(7'b0000100, f3(3,1), 7'b0, 7'b0, 1'b0, 21'h0, 1'b0));
        // After release, output 1 is IDLE, rr_ptr1 = 7 and 4 credits are back.
        rows.push_back(r(7'b0010010, f3(2,1) | f3(5,1), 7'b0010010, 7'b0, 1'b1, f3(1,2), 1'b0));
        rows.push_back(r(7'b0010010, f3(2,1) | f3(5,1), 7'b0010010, 7'b0, 1'b1, f3(1,5), 1'b0));
        rows.push_back(r(7'b0010010, f3(2,1) | f3(5,1), 7'b0010010, 7'b0, 1'b1, f3(1,2), 1'b0));
        rows.push_back(r(7'b0010010, f3(2,1) | f3(5,1), 7'b0010010, 7'b0, 1'b1, f3(1,5), 1'b0));
        rows.push_back(r(7'b0010010, f3(2,1) | f3(5,1), 7'b0010010, 7'b0, 1'b1, 21'h0, 1'b0));
        foreach (rows[k]) begin
            exp_q.push_back('{sa: rows[k].sa, er: rows[k].er});
            drive(rows[k]);
            e   = exp_q.pop_front();
            obs = {sa7, sa6, sa5, sa4, sa3, sa2, sa1};
            $display("test_credit_and_reset row %0d: sa=%h err=%b", k, obs, err);
            n_compared++;
            if (obs !== e.sa) begin
                n_mismatched++;
                $display("FAIL test_credit_and_reset row %0d sa: got %h required %h", k, obs, e.sa);
            end
        end
    endtask

    task automatic test_err_flag();
        row_t rows[$];
        exp_t e;
        logic [20:0] obs;
        rows.push_back(r(7'b0, 21'h0, 7'b0, 7'b0, 1'b0, 21'h0, 1'b0));
        rows.push_back(r(7'b0, 21'h0, 7'b0, 7'b0, 1'b1, 21'h0, 1'b0));
        // Surplus credit on output 1 (cnt1 = 4, no send).
        rows.push_back(r(7'b0, 21'h0, 7'b0, 7'b0000001, 1'b1, 21'h0, 1'b0));
        rows.push_back(r(7'b0, 21'h0, 7'b0, 7'b0, 1'b1, 21'h0, EE));
        rows.push_back(r(7'b0, 21'h0, 7'b0, 7'b0, 1'b1, 21'h0, EE));
        rows.push_back(r(7'b0, 21'h0, 7'b0, 7'b0, 1'b0, 21'h0, 1'b0));
        rows.push_back(r(7'b0, 21'h0, 7'b0, 7'b0, 1'b1, 21'h0, 1'b0));
        // A head flit with dest 0 gets no grant and is flagged.
        rows.push_back(r(7'b0001000, 21'h0, 7'b0001000, 7'b0, 1'b1, 21'h0, 1'b0));
        rows.push_back(r(7'b0, 21'h0, 7'b0, 7'b0, 1'b1, 21'h0, EE));
        rows.push_back(r(7'b0, 21'h0, 7'b0, 7'b0, 1'b0, 21'h0, 1'b0));
        foreach (rows[k]) begin
            exp_q.push_back('{sa: rows[k].sa, er: rows[k].er});
            drive(rows[k]);
            e   = exp_q.pop_front();
            obs = {sa7, sa6, sa5, sa4, sa3, sa2, sa1};
            $display("test_err_flag row %0d: sa=%h err=%b", k, obs, err);
            n_compared++;
            if (obs !== e.sa) begin
                n_mismatched++;
                $display("FAIL test_err_flag row %0d sa: got %h required %h", k, obs, e.sa);
            end
            n_compared++;
            if (err !== e.er) begin
                n_mismatched++;
                $display("FAIL test_err_flag row %0d err: got %b required %b", k, err, e.er);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        vc_valid  = '0;
        dest      = '0;
        tail      = '0;
        credit_in = '0;
        test_reset();
        test_single_flit();
        test_round_robin();
        test_wormhole();
        test_credit_exhaust();
        test_credit_and_reset();
        test_err_flag();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
